// File: rtl/data_sram_responder.sv
// MEM-stage data-memory responder: each 32-bit request becomes two 16-bit accesses
// to an external asynchronous SRAM, with the pipeline stalled via ready.
module data_sram_responder #(
    parameter int unsigned BASE_ADDR = 1024,
    parameter int unsigned SRAM_AW   = 18,
    parameter int unsigned WAIT      = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               MEM_R_EN,
    input  logic               MEM_W_EN,
    input  logic [31:0]        address,
    input  logic [31:0]        data,
    output logic [31:0]        MEM_result,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic               sram_we_n,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [15:0]        sram_dq_in
);

    localparam int unsigned CW = (WAIT > 1) ? $clog2(WAIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT - 1);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic               op_write;
    logic [SRAM_AW-2:0] word_q;
    logic [31:0]        data_q;

    logic               request;
    logic [31:0]        offset;
    logic [SRAM_AW-2:0] word;
    logic               unused_offset_bits;

    assign request = MEM_R_EN | MEM_W_EN;
    assign offset  = address - BASE_ADDR;
    // Byte offset within the word is ignored; upper bits wrap modulo the SRAM size.
    assign word    = offset[SRAM_AW:2];
    assign unused_offset_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};

    assign ready = ((state == IDLE) && !request) || (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            op_write    <= 1'b0;
            word_q      <= '0;
            data_q      <= '0;
            MEM_result  <= '0;
            sram_addr   <= '0;
            sram_we_n   <= 1'b1;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (request) begin
                        // A write wins when both enables are set.
                        op_write  <= MEM_W_EN;
                        word_q    <= word;
                        data_q    <= data;
                        cnt       <= '0;
                        state     <= LO;
                        sram_addr <= {word, 1'b0};
                        if (MEM_W_EN) begin
                            sram_we_n   <= 1'b0;
                            sram_dq_oe  <= 1'b1;
                            sram_dq_out <= data[15:0];
                        end
                    end
                end
                LO: begin
                    if (cnt == CNT_LAST) begin
                        cnt       <= '0;
                        state     <= HI;
                        sram_addr <= {word_q, 1'b1};
                        if (op_write) begin
                            sram_dq_out <= data_q[31:16];
                        end else begin
                            MEM_result[15:0] <= sram_dq_in;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HI: begin
                    if (cnt == CNT_LAST) begin
                        cnt        <= '0;
                        state      <= DONE;
                        sram_we_n  <= 1'b1;
                        sram_dq_oe <= 1'b0;
                        if (!op_write) begin
                            MEM_result[31:16] <= sram_dq_in;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_sram_responder.sv
// Self-checking bench for data_sram_responder: directed vector table, corner-case
// sequences, and random transactions against a transaction-level memory model.
module tb_data_sram_responder;

    localparam int unsigned BASE   = 1024;
    localparam int unsigned AW     = 18;
    localparam int unsigned WAIT_C = 2;

    logic        clk;
    logic        rst;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic [31:0] address;
    logic [31:0] data;
    logic [31:0] MEM_result;
    logic        ready;
    logic [17:0] sram_addr;
    logic        sram_we_n;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;

    int n_tests = 0;
    int n_fail  = 0;

    data_sram_responder #(
        .BASE_ADDR(BASE),
        .SRAM_AW  (AW),
        .WAIT     (WAIT_C)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .MEM_R_EN   (MEM_R_EN),
        .MEM_W_EN   (MEM_W_EN),
        .address    (address),
        .data       (data),
        .MEM_result (MEM_result),
        .ready      (ready),
        .sram_addr  (sram_addr),
        .sram_we_n  (sram_we_n),
        .sram_dq_out(sram_dq_out),
        .sram_dq_oe (sram_dq_oe),
        .sram_dq_in (sram_dq_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous SRAM: combinational read, write whenever the strobe is low at an edge.
    logic [15:0] sram [0:(1<<18)-1];
    logic        mem_clr;
    assign sram_dq_in = sram[sram_addr];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < (1 << 18); i++) sram[i] <= 16'h0;
        end else if (!sram_we_n) begin
            sram[sram_addr] <= sram_dq_out;
        end
    end

    // Reference model: halfword contents and the last read result.
    logic [15:0] model_mem [int];
    logic [31:0] model_result;

    function automatic logic [15:0] mm(input int idx);
        return model_mem.exists(idx) ? model_mem[idx] : 16'h0;
    endfunction

    function automatic logic [17:0] lo_of(input logic [31:0] a);
        logic [31:0] words;
        words = (a - BASE) / 4;
        return 18'((words % (32'd1 << (AW - 1))) * 2);
    endfunction

    function automatic logic [31:0] model_expect(input logic rd, input logic wr,
                                                 input logic [31:0] a);
        int lo;
        lo = int'(lo_of(a));
        if (rd && !wr) return {mm(lo + 1), mm(lo)};
        return model_result;
    endfunction

    task automatic model_apply(input logic rd, input logic wr, input logic [31:0] a,
                               input logic [31:0] d);
        int lo;
        lo = int'(lo_of(a));
        if (wr) begin
            model_mem[lo]     = d[15:0];
            model_mem[lo + 1] = d[31:16];
        end else if (rd) begin
            model_result = {mm(lo + 1), mm(lo)};
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // One full access, checked cycle by cycle from request to DONE.
    task automatic run_access(input logic rd, input logic wr, input logic [31:0] a,
                              input logic [31:0] d, input logic [17:0] exp_lo,
                              input logic [31:0] exp_res, input string tag);
        logic [31:0] half_addr;
        @(negedge clk);
        MEM_R_EN = rd;
        MEM_W_EN = wr;
        address  = a;
        data     = d;
        #1;
        check({tag, " ready c0"}, 32'(ready), 32'd0);
        check({tag, " we_n c0"}, 32'(sram_we_n), 32'd1);
        for (int k = 1; k <= 2 * WAIT_C; k++) begin
            @(negedge clk);
            // Latched copies must be used, so scrambling address/data is harmless.
            address = $urandom;
            data    = $urandom;
            half_addr = 32'(exp_lo) + ((k > WAIT_C) ? 32'd1 : 32'd0);
            check({tag, " ready busy"}, 32'(ready), 32'd0);
            check({tag, " sram_addr"}, 32'(sram_addr), half_addr);
            check({tag, " we_n busy"}, 32'(sram_we_n), 32'(!wr));
            check({tag, " oe busy"}, 32'(sram_dq_oe), 32'(wr));
            if (wr) begin
                check({tag, " dq_out"}, 32'(sram_dq_out),
                      (k > WAIT_C) ? 32'(d[31:16]) : 32'(d[15:0]));
            end
        end
        @(negedge clk);
        check({tag, " ready done"}, 32'(ready), 32'd1);
        check({tag, " we_n done"}, 32'(sram_we_n), 32'd1);
        check({tag, " oe done"}, 32'(sram_dq_oe), 32'd0);
        check({tag, " result"}, MEM_result, exp_res);
        MEM_R_EN = 1'b0;
        MEM_W_EN = 1'b0;
        if (wr) begin
            check({tag, " sram lo"}, 32'(sram[exp_lo]), 32'(d[15:0]));
            check({tag, " sram hi"}, 32'(sram[exp_lo + 18'd1]), 32'(d[31:16]));
        end
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] dat;
        logic [17:0] exp_lo;
        logic [31:0] exp_res;
    } vec_t;

    vec_t vecs [7];

    initial begin
        logic        rd;
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [17:0] lo;
        logic        exp_pat;
        logic [31:0] exp_res;

        vecs[0] = '{1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 18'd0,      32'h0};
        vecs[1] = '{1'b1, 1'b0, 32'd1024, 32'h0,        18'd0,      32'hDEADBEEF};
        vecs[2] = '{1'b0, 1'b1, 32'd1031, 32'h12345678, 18'd2,      32'hDEADBEEF};
        vecs[3] = '{1'b1, 1'b0, 32'd1020, 32'h0,        18'd262142, 32'h0};
        vecs[4] = '{1'b1, 1'b0, 32'd1028, 32'h0,        18'd2,      32'h12345678};
        vecs[5] = '{1'b1, 1'b1, 32'd1040, 32'hA5A55A5A, 18'd8,      32'h12345678};
        vecs[6] = '{1'b1, 1'b0, 32'd1040, 32'h0,        18'd8,      32'hA5A55A5A};

        model_result = 32'h0;
        rst      = 1'b1;
        mem_clr  = 1'b1;
        MEM_R_EN = 1'b0;
        MEM_W_EN = 1'b0;
        address  = 32'h0;
        data     = 32'h0;
        repeat (2) @(negedge clk);
        mem_clr = 1'b0;
        check("reset ready", 32'(ready), 32'd1);
        check("reset we_n", 32'(sram_we_n), 32'd1);
        check("reset oe", 32'(sram_dq_oe), 32'd0);
        check("reset addr", 32'(sram_addr), 32'd0);
        check("reset dq_out", 32'(sram_dq_out), 32'd0);
        check("reset result", MEM_result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle ready", 32'(ready), 32'd1);

        for (int i = 0; i < 7; i++) begin
            run_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].dat,
                       vecs[i].exp_lo, vecs[i].exp_res, $sformatf("vec%0d", i));
            model_apply(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].dat);
        end

        // Reset during the second LO cycle of a write: only the low half lands.
        @(negedge clk);
        MEM_W_EN = 1'b1;
        address  = 32'd1100;
        data     = 32'hCAFEF00D;
        @(negedge clk);
        @(negedge clk);
        rst      = 1'b1;
        MEM_W_EN = 1'b0;
        #1;
        check("rst mid we_n", 32'(sram_we_n), 32'd1);
        check("rst mid oe", 32'(sram_dq_oe), 32'd0);
        check("rst mid ready", 32'(ready), 32'd1);
        check("rst mid result", MEM_result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_result = 32'h0;
        model_mem[38] = 16'hF00D;
        check("partial lo", 32'(sram[38]), 32'(mm(38)));
        check("partial hi", 32'(sram[39]), 32'(mm(39)));
        run_access(1'b1, 1'b0, 32'd1100, 32'h0, 18'd38, {mm(39), mm(38)}, "after rst");
        model_apply(1'b1, 1'b0, 32'd1100, 32'h0);

        // Back-to-back reads with MEM_R_EN held through DONE and the following IDLE.
        @(negedge clk);
        MEM_R_EN = 1'b1;
        address  = 32'd1024;
        #1;
        check("b2b ready 0", 32'(ready), 32'd0);
        for (int i = 1; i < 12; i++) begin
            @(negedge clk);
            exp_pat = (i == 5) || (i == 11);
            check($sformatf("b2b ready %0d", i), 32'(ready), 32'(exp_pat));
        end
        model_apply(1'b1, 1'b0, 32'd1024, 32'h0);
        check("b2b result", MEM_result, model_result);
        MEM_R_EN = 1'b0;

        // Random transactions against the model.
        for (int t = 0; t < 40; t++) begin
            wr = 1'($urandom_range(0, 1));
            rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
            if ($urandom_range(0, 7) == 0) begin
                a = BASE - 32'($urandom_range(1, 4) * 4) + 32'($urandom_range(0, 3));
            end else begin
                a = BASE + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
            end
            d = $urandom;
            lo = lo_of(a);
            exp_res = model_expect(rd, wr, a);
            run_access(rd, wr, a, d, lo, exp_res, $sformatf("rnd%0d", t));
            model_apply(rd, wr, a, d);
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                check("gap ready", 32'(ready), 32'd1);
            end
        end

        foreach (model_mem[idx]) begin
            check($sformatf("final sram[%0d]", idx), 32'(sram[idx]), 32'(model_mem[idx]));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
